// File: rtl/calc_pkg.sv
// calc_pkg: constants and types shared by the calculator blocks.
//   - Instruction word layout: {funct[2:0], immA[15:0], immB[15:0]}.
//   - Host frame end marker and ALU function encodings.
//   - Program-loader FSM state type.
package calc_pkg;

  localparam int FUNCT_W = 3;
  localparam int IMM_W   = 16;
  localparam int INSTR_W = FUNCT_W + 2 * IMM_W;

  localparam logic [7:0] END_MARKER = 8'hFF;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 3'd0;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 3'd1;
  localparam logic [FUNCT_W-1:0] FUNCT_ACC = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } load_state_t;

  // True when the first byte of a frame has any reserved bit set.
  function automatic logic reserved_bad(input logic [7:0] b0);
    return b0[7:FUNCT_W] != '0;
  endfunction

endpackage

// File: rtl/calc_frame_asm.sv
// calc_frame_asm: assembles 5-byte host frames into instruction words.
// Ports:
//   clk, reset_n     - clock, synchronous active-low reset
//   clear            - discard any partial frame, restart at byte 0
//   byte_en          - a frame byte is accepted this cycle
//   byte_in          - the accepted byte
//   at_first         - next accepted byte is byte 0 of a frame
//   frame_complete   - byte_en on the 5th byte of a frame
//   frame_bad        - current frame had nonzero reserved bits in byte 0
//   frame_word       - full instruction word, valid with frame_complete
module calc_frame_asm
  import calc_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               byte_en,
  input  logic [7:0]         byte_in,
  output logic               at_first,
  output logic               frame_complete,
  output logic               frame_bad,
  output logic [INSTR_W-1:0] frame_word
);

  // Only funct and bytes 1..3 are stored; reserved bits are inspected, not
  // kept, and byte 4 joins the word directly on its way to memory.
  logic [INSTR_W-9:0] head;
  logic [2:0]         idx;
  logic               bad;

  assign at_first       = (idx == 3'd0);
  assign frame_complete = byte_en && (idx == 3'd4);
  assign frame_bad      = bad;
  assign frame_word     = {head, byte_in};

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      head <= '0;
      idx  <= 3'd0;
      bad  <= 1'b0;
    end else if (byte_en) begin
      if (idx == 3'd0) begin
        head <= {{(INSTR_W-8-FUNCT_W){1'b0}}, byte_in[FUNCT_W-1:0]};
        bad  <= reserved_bad(byte_in);
      end else begin
        head <= {head[INSTR_W-17:0], byte_in};
      end
      idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    end
  end

endmodule

// File: rtl/calc_prog_loader.sv
// calc_prog_loader: writes a host byte stream into instruction memory.
// Ports:
//   clk, reset_n   - clock, synchronous active-low reset
//   load_start     - pulse: (re)start a load at word address 0
//   in_valid/in_data/in_ready - host byte handshake
//   mem_we/mem_addr/mem_wdata - one-cycle instruction-memory write
//   loading, done, full, err  - load status (err is sticky per load)
//   prog_len       - words written in the current load
module calc_prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int INSTR_W = 35
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               loading,
  output logic               done,
  output logic               full,
  output logic               err,
  output logic [ADDR_W:0]    prog_len
);
  import calc_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  load_state_t        state;
  logic               accept;
  logic               end_seen;
  logic               at_first;
  logic               frame_complete;
  logic               frame_bad;
  logic [INSTR_W-1:0] frame_word;
  logic [ADDR_W:0]    len_inc;

  assign accept   = in_valid && in_ready;
  assign end_seen = accept && at_first && (in_data == END_MARKER);
  assign len_inc  = prog_len + {{ADDR_W{1'b0}}, 1'b1};

  // The end marker is a single byte and never enters the assembler.
  calc_frame_asm u_asm (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (load_start),
    .byte_en        (accept && !end_seen),
    .byte_in        (in_data),
    .at_first       (at_first),
    .frame_complete (frame_complete),
    .frame_bad      (frame_bad),
    .frame_word     (frame_word)
  );

  // load_start overrides everything but reset. A write already on the bus
  // in this cycle still lands because mem_we is high during the cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      loading   <= 1'b0;
      done      <= 1'b0;
      full      <= 1'b0;
      err       <= 1'b0;
      prog_len  <= '0;
    end else if (load_start) begin
      state    <= S_COLLECT;
      in_ready <= 1'b1;
      mem_we   <= 1'b0;
      loading  <= 1'b1;
      done     <= 1'b0;
      full     <= 1'b0;
      err      <= 1'b0;
      prog_len <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_COLLECT: begin
          if (end_seen) begin
            state    <= S_DONE;
            in_ready <= 1'b0;
            loading  <= 1'b0;
            done     <= 1'b1;
          end else if (accept) begin
            if (at_first && reserved_bad(in_data)) begin
              err <= 1'b1;
            end
            if (frame_complete && !frame_bad) begin
              state     <= S_WRITE;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= prog_len[ADDR_W-1:0];
              mem_wdata <= frame_word;
            end
          end
        end
        S_WRITE: begin
          prog_len <= len_inc;
          if (len_inc == DEPTH_CNT) begin
            state   <= S_DONE;
            loading <= 1'b0;
            done    <= 1'b1;
            full    <= 1'b1;
          end else begin
            state    <= S_COLLECT;
            in_ready <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_prog_loader.sv
// tb_calc_prog_loader: randomized self-checking bench for calc_prog_loader.
// A frame-level model parses the byte stream sent to the DUT and predicts
// the memory writes and the final status flags.
module tb_calc_prog_loader;

  localparam int TB_ADDR_W = 8;
  localparam int TB_DEPTH  = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 load_start;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 mem_we;
  logic [TB_ADDR_W-1:0] mem_addr;
  logic [34:0]          mem_wdata;
  logic                 loading;
  logic                 done;
  logic                 full;
  logic                 err;
  logic [TB_ADDR_W:0]   prog_len;

  int vectors = 0;
  int miscompares = 0;
  int we_ready_overlap = 0;

  logic [7:0]           stream[$];
  logic [34:0]          exp_words[$];
  logic [TB_ADDR_W-1:0] obs_addr[$];
  logic [34:0]          obs_data[$];
  logic                 exp_err, exp_full, exp_done;
  int                   exp_used;

  calc_prog_loader #(.ADDR_W(TB_ADDR_W), .DEPTH(TB_DEPTH), .INSTR_W(35)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .loading    (loading),
    .done       (done),
    .full       (full),
    .err        (err),
    .prog_len   (prog_len)
  );

  always #5 clk = ~clk;

  // Record every write strobe, and any cycle where the block offers
  // ready while it is writing.
  always @(negedge clk) begin
    if (mem_we) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      if (in_ready) we_ready_overlap++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Frame-level reference: 5-byte frames, FF as a lone first byte ends the
  // load, bad reserved bits drop a frame, nothing accepted once full.
  task automatic model_run();
    int i = 0;
    exp_words.delete();
    exp_err = 1'b0; exp_full = 1'b0; exp_done = 1'b0;
    while (i < stream.size()) begin
      if (exp_words.size() == TB_DEPTH) break;
      if (stream[i] == 8'hFF) begin exp_done = 1'b1; i++; break; end
      if (i + 5 > stream.size()) break;
      if (stream[i][7:3] != 5'd0) exp_err = 1'b1;
      else exp_words.push_back({stream[i][2:0], stream[i+1], stream[i+2],
                                stream[i+3], stream[i+4]});
      i += 5;
    end
    if (exp_words.size() == TB_DEPTH) begin exp_full = 1'b1; exp_done = 1'b1; end
    exp_used = i;
  endtask

  task automatic push_good_frame();
    stream.push_back({5'd0, 3'($urandom_range(0, 7))});
    repeat (4) stream.push_back(8'($urandom));
  endtask

  task automatic push_bad_frame();
    stream.push_back({5'($urandom_range(1, 30)), 3'($urandom_range(0, 7))});
    repeat (4) stream.push_back(8'($urandom));
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Offer one byte and return at the negedge after its handshake.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard = 0;
    if (stall) begin in_valid = 1'b0; @(negedge clk); end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("[TB] FAIL handshake_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input int stall_mode);
    for (int i = 0; i < exp_used; i++)
      send_byte(stream[i], (stall_mode == 2) ? bit'($urandom_range(0, 1)) : (stall_mode == 1));
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({in_ready, mem_we, loading, done, full, err} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, required 000000", {in_ready, mem_we, loading, done, full, err});
    end
    vectors++;
    if (prog_len !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: prog_len=%0d addr=%0d wdata=%h, required all 0", prog_len, mem_addr, mem_wdata);
    end
    reset_n = 1'b1;
    in_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || loading !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_ready: in_ready=%b loading=%b, required 0 0", in_ready, loading);
    end
  endtask

  task automatic test_single_frame();
    obs_addr.delete(); obs_data.delete();
    pulse_load();
    vectors++;
    if (loading !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_flags: loading=%b in_ready=%b done=%b, required 1 1 0", loading, in_ready, done);
    end
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    vectors++;
    if (mem_we !== 1'b1 || in_ready !== 1'b0 || mem_addr !== 8'd0 ||
        mem_wdata !== {3'b001, 16'h0005, 16'h0003}) begin
      miscompares++;
      $display("[TB] FAIL write_latency: we=%b ready=%b addr=%0d wdata=%h, required 1 0 0 %h",
               mem_we, in_ready, mem_addr, mem_wdata, {3'b001, 16'h0005, 16'h0003});
    end
    send_byte(8'hFF, 0);
    vectors++;
    if (done !== 1'b1 || loading !== 1'b0 || prog_len !== 9'd1 || obs_data.size() !== 1) begin
      miscompares++;
      $display("[TB] FAIL single_end: done=%b loading=%b prog_len=%0d writes=%0d, required 1 0 1 1",
               done, loading, prog_len, obs_data.size());
    end
    vectors++;
    if (mem_we !== 1'b0 || mem_wdata !== {3'b001, 16'h0005, 16'h0003}) begin
      miscompares++;
      $display("[TB] FAIL data_hold: we=%b wdata=%h, required 0 %h", mem_we, mem_wdata, {3'b001, 16'h0005, 16'h0003});
    end
  endtask

  task automatic test_stalled_frames();
    stream.delete();
    repeat (3) push_good_frame();
    stream.push_back(8'hFF);
    model_run();
    obs_addr.delete(); obs_data.delete(); we_ready_overlap = 0;
    pulse_load();
    send_stream(1);
    @(negedge clk);
    vectors++;
    if (obs_data.size() !== exp_words.size()) begin
      miscompares++;
      $display("[TB] FAIL stall_count: writes=%0d, required %0d", obs_data.size(), exp_words.size());
    end
    foreach (exp_words[k]) if (k < obs_data.size()) begin
      vectors++;
      if (obs_addr[k] !== 8'(k) || obs_data[k] !== exp_words[k]) begin
        miscompares++;
        $display("[TB] FAIL stall_write%0d: addr=%0d data=%h, required %0d %h", k, obs_addr[k], obs_data[k], k, exp_words[k]);
      end
    end
    vectors++;
    if (we_ready_overlap !== 0 || prog_len !== 9'd3 || done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_status: overlap=%0d prog_len=%0d done=%b, required 0 3 1", we_ready_overlap, prog_len, done);
    end
  endtask

  task automatic test_bad_frame();
    stream.delete();
    stream.push_back(8'h09); stream.push_back(8'h12); stream.push_back(8'h34);
    stream.push_back(8'h56); stream.push_back(8'h78);
    push_good_frame();
    stream.push_back(8'hFF);
    model_run();
    obs_addr.delete(); obs_data.delete();
    pulse_load();
    send_stream(2);
    @(negedge clk);
    vectors++;
    if (obs_data.size() !== 1) begin
      miscompares++;
      $display("[TB] FAIL bad_count: writes=%0d, required 1", obs_data.size());
    end else begin
      vectors++;
      if (obs_addr[0] !== 8'd0 || obs_data[0] !== exp_words[0]) begin
        miscompares++;
        $display("[TB] FAIL bad_next_write: addr=%0d data=%h, required 0 %h", obs_addr[0], obs_data[0], exp_words[0]);
      end
    end
    vectors++;
    if (err !== 1'b1 || prog_len !== 9'd1 || done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bad_status: err=%b prog_len=%0d done=%b, required 1 1 1", err, prog_len, done);
    end
  endtask

  task automatic test_full();
    bit seen_ready = 0;
    stream.delete();
    repeat (5) push_good_frame();
    model_run();
    obs_addr.delete(); obs_data.delete();
    pulse_load();
    send_stream(0);
    @(negedge clk); @(negedge clk);
    in_valid = 1'b1;
    in_data  = stream[exp_used];
    repeat (8) begin
      if (in_ready) seen_ready = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (obs_data.size() !== TB_DEPTH) begin
      miscompares++;
      $display("[TB] FAIL full_count: writes=%0d, required %0d", obs_data.size(), TB_DEPTH);
    end
    foreach (exp_words[k]) if (k < obs_data.size()) begin
      vectors++;
      if (obs_addr[k] !== 8'(k) || obs_data[k] !== exp_words[k]) begin
        miscompares++;
        $display("[TB] FAIL full_write%0d: addr=%0d data=%h, required %0d %h", k, obs_addr[k], obs_data[k], k, exp_words[k]);
      end
    end
    vectors++;
    if (full !== 1'b1 || done !== 1'b1 || loading !== 1'b0 || prog_len !== 9'(TB_DEPTH) || seen_ready) begin
      miscompares++;
      $display("[TB] FAIL full_status: full=%b done=%b loading=%b prog_len=%0d ready_seen=%b, required 1 1 0 %0d 0",
               full, done, loading, prog_len, seen_ready, TB_DEPTH);
    end
  endtask

  task automatic test_abort();
    obs_addr.delete(); obs_data.delete();
    pulse_load();
    send_byte(8'h03, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    pulse_load();
    send_byte(8'h02, 0); send_byte(8'hAB, 0); send_byte(8'hCD, 0);
    send_byte(8'hEF, 0); send_byte(8'h01, 0); send_byte(8'hFF, 0);
    vectors++;
    if (obs_data.size() !== 1) begin
      miscompares++;
      $display("[TB] FAIL abort_count: writes=%0d, required 1", obs_data.size());
    end else begin
      vectors++;
      if (obs_addr[0] !== 8'd0 || obs_data[0] !== {3'b010, 16'hABCD, 16'hEF01}) begin
        miscompares++;
        $display("[TB] FAIL abort_write: addr=%0d data=%h, required 0 %h", obs_addr[0], obs_data[0], {3'b010, 16'hABCD, 16'hEF01});
      end
    end
    vectors++;
    if (prog_len !== 9'd1 || err !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_status: prog_len=%0d err=%b done=%b, required 1 0 1", prog_len, err, done);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit seen_ready = 0;
    obs_addr.delete(); obs_data.delete();
    pulse_load();
    send_byte(8'h04, 0); send_byte(8'h11, 0);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h22;
    @(negedge clk);
    vectors++;
    if ({in_ready, mem_we, loading, done, full, err} !== 6'b0 || prog_len !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_flags: flags=%b prog_len=%0d, required 000000 0",
               {in_ready, mem_we, loading, done, full, err}, prog_len);
    end
    reset_n = 1'b1;
    repeat (10) begin
      if (in_ready) seen_ready = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (obs_data.size() !== 0 || seen_ready) begin
      miscompares++;
      $display("[TB] FAIL midreset_nowrite: writes=%0d ready_seen=%b, required 0 0", obs_data.size(), seen_ready);
    end
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 8; it++) begin
      stream.delete();
      repeat ($urandom_range(0, 5)) begin
        if ($urandom_range(0, 3) == 0) push_bad_frame();
        else push_good_frame();
      end
      stream.push_back(8'hFF);
      model_run();
      obs_addr.delete(); obs_data.delete();
      pulse_load();
      send_stream(2);
      @(negedge clk); @(negedge clk);
      vectors++;
      if (obs_data.size() !== exp_words.size()) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_count: writes=%0d, required %0d", it, obs_data.size(), exp_words.size());
      end
      foreach (exp_words[k]) if (k < obs_data.size()) begin
        vectors++;
        if (obs_addr[k] !== 8'(k) || obs_data[k] !== exp_words[k]) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_write%0d: addr=%0d data=%h, required %0d %h", it, k, obs_addr[k], obs_data[k], k, exp_words[k]);
        end
      end
      vectors++;
      if (err !== exp_err || full !== exp_full || done !== exp_done || loading !== 1'b0 ||
          prog_len !== 9'(exp_words.size())) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_status: err=%b full=%b done=%b loading=%b len=%0d, required %b %b %b 0 %0d",
                 it, err, full, done, loading, prog_len, exp_err, exp_full, exp_done, exp_words.size());
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_stalled_frames();
    test_bad_frame();
    test_full();
    test_abort();
    test_reset_mid_frame();
    test_random_loads();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
